shot_board_reg: RTL and testbench
=================================

# shot_board_reg

Parametrised shot-history register for the Batalla Naval board. Holds one ROWS×COLS "already fired" bit-matrix per player and accepts shots through a valid/ready handshake. Answers each accepted shot one cycle later with fresh/repeat/error status, and keeps a per-player shot count and full flag. Supports a row-sweeping per-player clear so a new round can start without a global reset. Sits between the shot-input FSM and the hit/miss game logic.

## Interface
- ROWS, 5, board rows (≥2)
- COLS, 5, board columns (≥2)
- PLAYERS, 2, number of independent boards (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- shot_valid  in  1  shot request
- shot_ready  out  1  block can accept a shot this cycle
- shot_player  in  PW=$clog2(PLAYERS) (min 1)  target board
- shot_row  in  RW=$clog2(ROWS)  row index
- shot_col  in  CW=$clog2(COLS)  column index
- resp_valid  out  1  one-cycle response strobe
- resp_fresh  out  1  cell was unshot and is now marked
- resp_err  out  1  player/row/col out of range; nothing marked
- rd_player / rd_row / rd_col  in  PW/RW/CW  query address
- rd_shot  out  1  registered query result
- clr_req  in  1  start clearing board clr_player
- clr_player  in  PW  board to clear
- clr_done  out  1  one-cycle pulse on the last clear cycle
- shot_count  out  PLAYERS×NW, NW=$clog2(ROWS*COLS+1)  per-player marked-cell count, packed, player 0 in the LSBs
- board_full  out  PLAYERS  count == ROWS*COLS

## Operation
- Reset (reset=0): all matrices 0, counts 0, state IDLE, every output 0 except shot_ready=1 once reset is released.
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR on clr_req=1. Latch clr_player and set row pointer r=0.
- CLEAR: each cycle, zero row r of the latched board and increment r.
- CLEAR → IDLE after row ROWS-1 is cleared. clr_done pulses in that cycle.
- shot_count of the cleared board goes to 0 at the first CLEAR edge.
- clr_req while in CLEAR is ignored.
- shot_ready = (state==IDLE) && !clr_req, so a clear beats a simultaneous shot.
- A shot is accepted only when shot_valid && shot_ready.
- Accepted shot, response in the next cycle:
  - Any index out of range: resp_err=1, resp_fresh=0, no state change.
  - Cell already 1: resp_fresh=0, resp_err=0, no change.
  - Cell 0: cell set to 1, count incremented, resp_fresh=1.
- Count never exceeds ROWS*COLS (saturating by construction). A full board answers every in-range shot as a repeat.
- Read port: rd_shot at edge N+1 reflects the matrix as it was before edge N+1. Out-of-range query returns 0.
- Reset asserted mid-clear or mid-response: immediate return to reset values; the response is lost.

## Timing
- Shot → response latency: 1 cycle. resp_valid is a single-cycle pulse per accepted shot.
- Back-to-back shots: one per cycle. Two consecutive shots to the same cell return fresh=1 then fresh=0, with no forwarding needed because the matrix updates at the accept edge.
- Clear takes exactly ROWS cycles. shot_ready is low from the clr_req cycle through the clr_done cycle, and high again the following cycle.
- shot_count and board_full update at the same edge that sets resp_valid.

## Structure
- Package shot_board_pkg holds:
  - state enum {IDLE, CLEAR}
  - width helpers (PW/RW/CW/NW computed with $clog2, minimum 1)
- Single flat module. The matrix is an array [PLAYERS][ROWS][COLS] of bits. No sub-module is needed.

## Test plan
- Reset, then shot (p0, 2, 3) → next cycle resp_valid=1, fresh=1. shot_count[p0]=1. rd(p0,2,3) → rd_shot=1.
- Same shot repeated back-to-back → responses fresh=1 then fresh=0. Count stays 1.
- shot_row=5 with ROWS=5 → resp_err=1, fresh=0, counts unchanged.
- Fire all 25 cells of p1 → board_full[1]=1, count=25. A 26th shot gives fresh=0 and count stays 25. p0 is unaffected.
- clr_req(p1) together with shot_valid → shot not accepted; shot_ready low for 5 cycles; clr_done on the 5th; p1 count 0 and all cells 0; p0 unchanged.
- reset asserted in the 2nd clear cycle → all outputs return to reset values immediately. shot_ready=1 after release.

Source files
------------

// File: rtl/shot_board_pkg.sv
// Shared state type and width helpers for the shot-history board register.
package shot_board_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;

  // Bits needed to index n distinct values, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shot_board_reg.sv
// Per-player "already fired" matrices with a valid/ready shot port, one-cycle
// fresh/repeat/error response, read port, shot counters and a row-sweeping clear.
//
//   state | meaning
//   IDLE  | accepting shots unless a clear is being requested
//   CLEAR | zeroing one row of the latched board per cycle
module shot_board_reg
  import shot_board_pkg::*;
#(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int PLAYERS = 2,
  localparam int PW = width_of(PLAYERS),
  localparam int RW = width_of(ROWS),
  localparam int CW = width_of(COLS),
  localparam int NW = width_of(ROWS * COLS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shot_valid,
  output logic                  shot_ready,
  input  logic [PW-1:0]         shot_player,
  input  logic [RW-1:0]         shot_row,
  input  logic [CW-1:0]         shot_col,
  output logic                  resp_valid,
  output logic                  resp_fresh,
  output logic                  resp_err,
  input  logic [PW-1:0]         rd_player,
  input  logic [RW-1:0]         rd_row,
  input  logic [CW-1:0]         rd_col,
  output logic                  rd_shot,
  input  logic                  clr_req,
  input  logic [PW-1:0]         clr_player,
  output logic                  clr_done,
  output logic [PLAYERS*NW-1:0] shot_count,
  output logic [PLAYERS-1:0]    board_full
);

  state_t        state;
  logic [RW-1:0] row_ptr;
  logic [PW-1:0] clr_sel;
  logic          board [PLAYERS][ROWS][COLS];
  logic [NW-1:0] cnt [PLAYERS];

  logic shot_acc;
  logic shot_in_range;
  logic rd_in_range;

  // A pending clear request wins over a shot offered in the same cycle.
  assign shot_ready    = reset && (state == IDLE) && !clr_req;
  assign shot_acc      = shot_valid && shot_ready;
  assign shot_in_range = (int'(shot_player) < PLAYERS) && (int'(shot_row) < ROWS) &&
                         (int'(shot_col) < COLS);
  assign rd_in_range   = (int'(rd_player) < PLAYERS) && (int'(rd_row) < ROWS) &&
                         (int'(rd_col) < COLS);

  always_comb begin
    shot_count = '0;
    board_full = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      shot_count[p*NW +: NW] = cnt[p];
      board_full[p]          = (int'(cnt[p]) == ROWS * COLS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row_ptr    <= '0;
      clr_sel    <= '0;
      clr_done   <= 1'b0;
      resp_valid <= 1'b0;
      resp_fresh <= 1'b0;
      resp_err   <= 1'b0;
      rd_shot    <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        cnt[p] <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            board[p][r][c] <= 1'b0;
      end
    end else begin
      resp_valid <= shot_acc;
      resp_fresh <= 1'b0;
      resp_err   <= 1'b0;
      clr_done   <= 1'b0;
      rd_shot    <= rd_in_range ? board[rd_player][rd_row][rd_col] : 1'b0;

      if (shot_acc) begin
        if (!shot_in_range) begin
          resp_err <= 1'b1;
        end else if (!board[shot_player][shot_row][shot_col]) begin
          board[shot_player][shot_row][shot_col] <= 1'b1;
          cnt[shot_player]                       <= cnt[shot_player] + 1'b1;
          resp_fresh                             <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_sel <= clr_player;
            row_ptr <= '0;
            if (int'(clr_player) < PLAYERS)
              cnt[clr_player] <= '0;
          end
        end
        CLEAR: begin
          if (int'(clr_sel) < PLAYERS)
            for (int c = 0; c < COLS; c++)
              board[clr_sel][row_ptr][c] <= 1'b0;
          // Registered so the pulse lands in the cycle that clears the last row.
          clr_done <= (int'(row_ptr) == ROWS - 2);
          if (int'(row_ptr) == ROWS - 1)
            state <= IDLE;
          else
            row_ptr <= row_ptr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_board_reg.sv
// Self-checking bench for shot_board_reg: directed scenarios plus random traffic,
// compared every cycle against a board model kept as plain arrays and counters.
module tb_shot_board_reg;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int PLAYERS = 2;
  localparam int PW = 1;
  localparam int RW = 3;
  localparam int CW = 3;
  localparam int NW = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  shot_valid = 1'b0;
  logic                  shot_ready;
  logic [PW-1:0]         shot_player = '0;
  logic [RW-1:0]         shot_row = '0;
  logic [CW-1:0]         shot_col = '0;
  logic                  resp_valid, resp_fresh, resp_err;
  logic [PW-1:0]         rd_player = '0;
  logic [RW-1:0]         rd_row = '0;
  logic [CW-1:0]         rd_col = '0;
  logic                  rd_shot;
  logic                  clr_req = 1'b0;
  logic [PW-1:0]         clr_player = '0;
  logic                  clr_done;
  logic [PLAYERS*NW-1:0] shot_count;
  logic [PLAYERS-1:0]    board_full;

  shot_board_reg #(.ROWS(ROWS), .COLS(COLS), .PLAYERS(PLAYERS)) dut (
    .clk(clk), .reset(reset),
    .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_player(shot_player), .shot_row(shot_row), .shot_col(shot_col),
    .resp_valid(resp_valid), .resp_fresh(resp_fresh), .resp_err(resp_err),
    .rd_player(rd_player), .rd_row(rd_row), .rd_col(rd_col), .rd_shot(rd_shot),
    .clr_req(clr_req), .clr_player(clr_player), .clr_done(clr_done),
    .shot_count(shot_count), .board_full(board_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: marked cells, marked-cell counts, rows still to clear.
  bit m_board [PLAYERS][ROWS][COLS];
  int e_cnt [PLAYERS];
  int clear_left = 0;
  int m_pl = 0;
  bit e_rv = 0, e_fr = 0, e_er = 0, e_rd = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (m_board[p, r, c]) m_board[p][r][c] = 0;
      foreach (e_cnt[p]) e_cnt[p] = 0;
      clear_left = 0;
      e_rv = 0; e_fr = 0; e_er = 0; e_rd = 0;
    end else begin
      bit acc;
      int sp, sr, sc;
      acc = shot_valid && (clear_left == 0) && !clr_req;
      sp = int'(shot_player); sr = int'(shot_row); sc = int'(shot_col);
      if (int'(rd_player) < PLAYERS && int'(rd_row) < ROWS && int'(rd_col) < COLS)
        e_rd = m_board[int'(rd_player)][int'(rd_row)][int'(rd_col)];
      else
        e_rd = 0;
      e_rv = acc; e_fr = 0; e_er = 0;
      if (clear_left > 0) begin
        for (int c = 0; c < COLS; c++) m_board[m_pl][ROWS - clear_left][c] = 0;
        clear_left--;
      end else if (clr_req) begin
        clear_left = ROWS;
        m_pl = int'(clr_player);
        e_cnt[m_pl] = 0;
      end
      if (acc) begin
        if (sp >= PLAYERS || sr >= ROWS || sc >= COLS) e_er = 1;
        else if (!m_board[sp][sr][sc]) begin
          m_board[sp][sr][sc] = 1;
          e_cnt[sp]++;
          e_fr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("shot_ready", int'(shot_ready), int'(reset && clear_left == 0 && !clr_req));
    chk("resp_valid", int'(resp_valid), int'(e_rv));
    if (e_rv) begin
      chk("resp_fresh", int'(resp_fresh), int'(e_fr));
      chk("resp_err", int'(resp_err), int'(e_er));
    end
    chk("rd_shot", int'(rd_shot), int'(e_rd));
    chk("clr_done", int'(clr_done), int'(clear_left == 1));
    for (int p = 0; p < PLAYERS; p++) begin
      chk("shot_count", int'(shot_count[p*NW +: NW]), e_cnt[p]);
      chk("board_full", int'(board_full[p]), int'(e_cnt[p] == ROWS * COLS));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    shot_valid = 0;
    clr_req = 0;
  endtask

  task automatic shot(input int p, input int r, input int c);
    shot_player = PW'(p);
    shot_row = RW'(r);
    shot_col = CW'(c);
    shot_valid = 1;
    step();
  endtask

  int cells [ROWS*COLS];

  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1;
    @(negedge clk);
    chk("ready_after_reset", int'(shot_ready), 1);
    chk("count_after_reset", int'(shot_count), 0);

    shot(0, 2, 3);
    @(negedge clk);
    chk("first_resp_valid", int'(resp_valid), 1);
    chk("first_resp_fresh", int'(resp_fresh), 1);
    chk("first_count_p0", int'(shot_count[NW-1:0]), 1);
    rd_player = 0; rd_row = 2; rd_col = 3;
    step();
    @(negedge clk);
    chk("rd_first_cell", int'(rd_shot), 1);

    shot(0, 4, 4);
    shot(0, 4, 4);
    @(negedge clk);
    chk("repeat_fresh", int'(resp_fresh), 0);
    chk("repeat_count_p0", int'(shot_count[NW-1:0]), 2);

    shot(0, 5, 0);
    @(negedge clk);
    chk("row5_err", int'(resp_err), 1);
    chk("row5_count_p0", int'(shot_count[NW-1:0]), 2);

    for (int i = 0; i < ROWS * COLS; i++) cells[i] = i;
    for (int i = ROWS * COLS - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = cells[i]; cells[i] = cells[j]; cells[j] = t;
    end
    for (int i = 0; i < ROWS * COLS; i++) shot(1, cells[i] / COLS, cells[i] % COLS);
    shot(1, 0, 0);
    @(negedge clk);
    chk("full_26th_fresh", int'(resp_fresh), 0);
    chk("full_flags", int'(board_full), 2);
    chk("full_count_p1", int'(shot_count[2*NW-1:NW]), 25);
    chk("full_count_p0", int'(shot_count[NW-1:0]), 2);

    clr_player = 1; clr_req = 1;
    shot_player = 0; shot_row = 0; shot_col = 0; shot_valid = 1;
    step();
    for (int k = 1; k <= ROWS; k++) begin
      @(negedge clk);
      chk("clr_ready_low", int'(shot_ready), 0);
      chk("clr_done_cycle", int'(clr_done), int'(k == ROWS));
      if (k == 1) chk("clr_shot_dropped", int'(resp_valid), 0);
      step();
    end
    @(negedge clk);
    chk("clr_ready_back", int'(shot_ready), 1);
    chk("clr_count_p1", int'(shot_count[2*NW-1:NW]), 0);
    chk("clr_count_p0", int'(shot_count[NW-1:0]), 2);
    for (int i = 0; i < ROWS * COLS; i++) begin
      rd_player = 1; rd_row = RW'(i / COLS); rd_col = CW'(i % COLS);
      step();
    end

    for (int i = 0; i < 600; i++) begin
      shot_valid = 1'($urandom_range(0, 1));
      shot_player = PW'($urandom_range(0, 1));
      shot_row = RW'($urandom_range(0, 6));
      shot_col = CW'($urandom_range(0, 6));
      rd_player = PW'($urandom_range(0, 1));
      rd_row = RW'($urandom_range(0, 6));
      rd_col = CW'($urandom_range(0, 6));
      clr_player = PW'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    shot_valid = 0; clr_req = 0;
    repeat (ROWS + 2) step();

    shot(0, 1, 2);
    clr_player = 0; clr_req = 1;
    step();
    step();
    #2 reset = 0;
    #1;
    chk("rst_ready", int'(shot_ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    chk("rst_counts", int'(shot_count), 0);
    chk("rst_full", int'(board_full), 0);
    chk("rst_rd_shot", int'(rd_shot), 0);
    @(posedge clk);
    #3 reset = 1;
    @(negedge clk);
    chk("ready_after_rerelease", int'(shot_ready), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
